multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//  Sequencer for a W-bit adder (b_bit_adder) to perform N*W-bit multi-precision addition one W-bit word per cycle.
//  Latches operands on start, walks words LSW->MSW, chains carry through a register, collects sum words.
//  Drives the adder via adder_* ports; the adder is instantiated outside this block.
// PARAMETERS
//  W  8  adder/word width in bits
//  N  4  number of words per operand (N>=1); operand width = N*W
// PORTS
//  clk         in   1    clock, all state updates on rising edge
//  reset       in   1    synchronous, active-high reset
//  start       in   1    request; sampled only in IDLE
//  a_in        in   N*W  operand A, latched on accepted start
//  b_in        in   N*W  operand B, latched on accepted start
//  cin_in      in   1    carry-in to word 0, latched on accepted start
//  busy        out  1    high in RUN and DONE
//  done        out  1    one-cycle pulse, result valid
//  sum_out     out  N*W  result; held until next accepted start
//  cout_out    out  1    final carry out of word N-1; held with sum_out
//  adder_a     out  W    to adder: A word idx
//  adder_b     out  W    to adder: B word idx
//  adder_cin   out  1    to adder: carry register
//  adder_sum   in   W    from adder: sum word (combinational)
//  adder_cout  in   1    from adder: carry out (combinational)
// BEHAVIOUR
//  One clock; reset synchronous active-high, wins over all other inputs.
//  Reset values: state=IDLE, idx=0, carry=0, busy=0, done=0, sum_out=0, cout_out=0.
//  States: IDLE, RUN, DONE.
//  IDLE: adder_a/adder_b/adder_cin driven 0. start=1 -> latch a_in,b_in into a_reg,b_reg,
//   carry<=cin_in, idx<=0, -> RUN. sum_out/cout_out unchanged until first RUN edge.
//  RUN: adder_a=a_reg[idx*W+:W], adder_b=b_reg[idx*W+:W], adder_cin=carry (combinational).
//   Each edge: sum_out[idx*W+:W]<=adder_sum, carry<=adder_cout, idx<=idx+1.
//   idx==N-1: cout_out<=adder_cout, -> DONE (idx not incremented past N-1).
//  DONE: done=1 for exactly this cycle; -> IDLE unconditionally.
//  Latency: start sampled at edge 0 -> RUN edges 1..N -> done high in cycle after edge N;
//   N+1 cycles start-to-done; next start accepted at earliest edge N+2.
//  start while busy (RUN or DONE): ignored, no queueing; latched operands unaffected.
//  a_in/b_in/cin_in changes after acceptance: no effect on result.
//  N=1: single RUN cycle, done one cycle later.
//  Carry wraps only within the operation: final carry to cout_out, not fed into next op.
//  Reset mid-RUN/DONE: IDLE next cycle, partial result discarded, all outputs at reset values.
//  Adder assumed purely combinational, settling within one cycle.
// CONFIGURATION
//  MWADD_SUB_EN defined: extra port sub_in (in, 1), latched on accepted start.
//   sub_in=1: b_reg<=~b_in, carry<=1 (cin_in ignored) -> A-B in two's complement;
//   cout_out=1 means no borrow (A>=B unsigned). sub_in=0: identical to plain add.
//  MWADD_SUB_EN undefined: no sub_in port; add only.
// TESTING (W=8, N=4)
//  a=0x00000017,b=0x0000002D,cin=1 -> done 5 cycles after start, sum_out=0x00000045, cout_out=0.
//  a=0xFFFFFFFF,b=0x00000001,cin=0 -> sum_out=0, cout_out=1; adder_cin=1 in RUN cycles 2,3,4.
//  a=0x80000000,b=0x80000000,cin=0 -> sum_out=0x00000000, cout_out=1; busy high 5 cycles.
//  start re-pulsed in RUN with new operands -> ignored; result of first op, single done pulse.
//  reset in 2nd RUN cycle -> next cycle busy=0,done=0,sum_out=0; following start 0x1+0x2 -> sum_out=0x3.
//  MWADD_SUB_EN: 0x22-0x17 -> sum_out=0x0000000B,cout_out=1; 0x17-0x22 -> sum_out=0xFFFFFFF5,cout_out=0.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Sequencer driving an external W-bit adder to add two N*W-bit operands one word per cycle, LSW first.
// Optional subtraction mode (A-B) enabled by defining MWADD_SUB_EN, which adds the sub_in port.
module multiword_add_seq #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    input  logic           cin_in,
`ifdef MWADD_SUB_EN
    input  logic           sub_in,
`endif
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] sum_out,
    output logic           cout_out,
    output logic [W-1:0]   adder_a,
    output logic [W-1:0]   adder_b,
    output logic           adder_cin,
    input  logic [W-1:0]   adder_sum,
    input  logic           adder_cout
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [N*W-1:0] a_reg, b_reg;
    logic           accept;
    logic [N*W-1:0] b_sel;
    logic           cin_sel;

    assign accept = (state == IDLE) && start;

`ifdef MWADD_SUB_EN
    // Subtraction is A + ~B + 1; the caller's carry-in is deliberately ignored.
    assign b_sel   = sub_in ? ~b_in : b_in;
    assign cin_sel = sub_in ? 1'b1  : cin_in;
`else
    assign b_sel   = b_in;
    assign cin_sel = cin_in;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a_in;
            b_reg <= b_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        carry <= cin_sel;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_out[idx*W +: W] <= adder_sum;
                    carry               <= adder_cout;
                    if (idx == LAST) begin
                        cout_out <= adder_cout;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                adder_a   = a_reg[idx*W +: W];
                adder_b   = b_reg[idx*W +: W];
                adder_cin = carry;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (W=8, N=4) with a behavioural combinational adder attached.
module tb_multiword_add_seq;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset, start, cin_in;
    logic [N*W-1:0] a_in, b_in, sum_out;
    logic           busy, done, cout_out;
    logic [W-1:0]   adder_a, adder_b, adder_sum;
    logic           adder_cin, adder_cout;
`ifdef MWADD_SUB_EN
    logic           sub_in = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_cin};

    multiword_add_seq #(.W(W), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
`ifdef MWADD_SUB_EN
        .sub_in(sub_in),
`endif
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic [3:0]  cseq;   // adder_cin in RUN cycles 4..1 (bit0 = first RUN cycle)
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called right after the accepting edge; follows the op to its done pulse and one cycle beyond.
    task automatic follow(output int lat, output int busyc, output logic [3:0] cseq,
                          output logic done_after, output logic busy_after);
        int k;
        lat = 1; busyc = busy ? 1 : 0; cseq = '0; k = 0;
        if (busy && !done) begin cseq[0] = adder_cin; k = 1; end
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busyc++;
            if (busy && !done && k < 4) begin cseq[k] = adder_cin; k++; end
        end
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    initial begin
        int lat, busyc, dpulses;
        logic [3:0] cseq;
        logic da, ba;

        vecs[0] = '{32'h00000017, 32'h0000002D, 1'b1, 32'h00000045, 1'b0, 4'b0001};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 4'b1110};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 4'b0000};
        vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 4'b0000};
        vecs[4] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 4'b1010};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b1111};

        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum_out), 64'd0);
        chk("rst_cout", 64'(cout_out), 64'd0);
        chk("rst_adder", {adder_a, adder_b, 7'd0, adder_cin}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            follow(lat, busyc, cseq, da, ba);
            chk($sformatf("v%0d_sum", i), 64'(sum_out), 64'(vecs[i].sum));
            chk($sformatf("v%0d_cout", i), 64'(cout_out), 64'(vecs[i].cout));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
            chk($sformatf("v%0d_busy_cycles", i), 64'(busyc), 64'd5);
            chk($sformatf("v%0d_adder_cin_seq", i), 64'(cseq), 64'(vecs[i].cseq));
            chk($sformatf("v%0d_done_one_cycle", i), {62'd0, da, ba}, 64'd0);
        end

        // Start re-pulsed during RUN with different operands must be ignored.
        launch(32'h00000017, 32'h0000002D, 1'b1);
        @(negedge clk);
        a_in = 32'hFFFFFFFF; b_in = 32'h00000001; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dpulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) dpulses++;
            @(posedge clk); #1;
        end
        chk("restart_sum", 64'(sum_out), 64'h45);
        chk("restart_cout", 64'(cout_out), 64'd0);
        chk("restart_done_pulses", 64'(dpulses), 64'd1);

        // Reset sampled at the edge ending the 2nd RUN cycle.
        launch(32'hFFFFFFFF, 32'h00000001, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_sum", 64'(sum_out), 64'd0);
        chk("midrst_cout", 64'(cout_out), 64'd0);
        launch(32'h00000001, 32'h00000002, 1'b0);
        follow(lat, busyc, cseq, da, ba);
        chk("postrst_sum", 64'(sum_out), 64'h3);
        chk("postrst_latency", 64'(lat), 64'd5);

        // Result held through the accepting edge of the next operation.
        launch(32'h00000005, 32'h00000005, 1'b0);
        chk("hold_at_accept", 64'(sum_out), 64'h3);
        follow(lat, busyc, cseq, da, ba);
        chk("hold_next_sum", 64'(sum_out), 64'hA);

`ifdef MWADD_SUB_EN
        sub_in = 1'b1;
        launch(32'h00000022, 32'h00000017, 1'b0);
        sub_in = 1'b0;
        follow(lat, busyc, cseq, da, ba);
        chk("sub_pos_sum", 64'(sum_out), 64'h0000000B);
        chk("sub_pos_cout", 64'(cout_out), 64'd1);
        sub_in = 1'b1;
        launch(32'h00000017, 32'h00000022, 1'b1);
        sub_in = 1'b0;
        follow(lat, busyc, cseq, da, ba);
        chk("sub_neg_sum", 64'(sum_out), 64'hFFFFFFF5);
        chk("sub_neg_cout", 64'(cout_out), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
